// File: rtl/hbm_ctrl_pkg.sv
// Shared command encoding for the core/controller stream link.
package hbm_ctrl_pkg;

    localparam int   CMD_OP_BIT   = 22;
    localparam int   CMD_ADDR_MSB = 21;
    localparam logic CMD_OP_WRITE = 1'b1;
    localparam logic CMD_OP_READ  = 1'b0;

    // Command word as carried on s_axis_wr_tuser.
    typedef struct packed {
        logic                  op;
        logic [CMD_ADDR_MSB:0] addr;
    } cmd_t;

endpackage

// File: rtl/hbm_rsp_fifo.sv
// Read-response FIFO: synchronous, first-word-fall-through, with occupancy count.
// The caller guarantees no push when full (credit accounting upstream).
module hbm_rsp_fifo #(
    parameter int WIDTH = 1024,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    // Empty FIFO presents zero so the output bus is clean out of reset.
    assign dout   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/hbm_cmd_responder.sv
// Controller-side endpoint backed by an on-chip byte-enabled word memory.
// Commands complete strictly in acceptance order; reads return through a
// small response FIFO guarded by a credit counter.
// Optional macro HBM_RSP_ADDR_CHECK_EN: flags commands whose address exceeds
// the memory depth, drops such writes, returns zero for such reads and adds
// the sticky o_addr_err output.
module hbm_cmd_responder
    import hbm_ctrl_pkg::*;
#(
    parameter int C_S_AXIS_WR_TUSER_WIDTH = 23,
    parameter int C_S_AXIS_WR_TDATA_WIDTH = 1024,
    parameter int C_M_AXIS_RD_TDATA_WIDTH = 1024,
    parameter int MEM_ADDR_WIDTH          = 10,
    parameter int RSP_FIFO_DEPTH          = 4
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst,
    input  logic                                 s_axis_wr_tvalid,
    output logic                                 s_axis_wr_tready,
    input  logic [C_S_AXIS_WR_TDATA_WIDTH-1:0]   s_axis_wr_tdata,
    input  logic [C_S_AXIS_WR_TUSER_WIDTH-1:0]   s_axis_wr_tuser,
    input  logic [C_S_AXIS_WR_TDATA_WIDTH/8-1:0] s_axis_wr_tkeep,
    input  logic                                 s_axis_wr_tlast,
    output logic                                 m_axis_rd_tvalid,
    input  logic                                 m_axis_rd_tready,
    output logic [C_M_AXIS_RD_TDATA_WIDTH-1:0]   m_axis_rd_tdata,
    output logic [C_M_AXIS_RD_TDATA_WIDTH/8-1:0] m_axis_rd_tkeep,
    output logic                                 m_axis_rd_tlast
`ifdef HBM_RSP_ADDR_CHECK_EN
    ,
    output logic                                 o_addr_err
`endif
);

    localparam int TDW   = C_S_AXIS_WR_TDATA_WIDTH;
    localparam int KW    = TDW / 8;
    localparam int WORDS = 1 << MEM_ADDR_WIDTH;
    localparam int CW    = $clog2(RSP_FIFO_DEPTH) + 1;

    if (C_S_AXIS_WR_TDATA_WIDTH != C_M_AXIS_RD_TDATA_WIDTH) begin : g_width_err
        $error("hbm_cmd_responder: read and write data widths must match");
    end
    if (C_S_AXIS_WR_TUSER_WIDTH != 23) begin : g_tuser_err
        $error("hbm_cmd_responder: tuser width must be 23");
    end

    cmd_t                      cmd;
    logic [MEM_ADDR_WIDTH-1:0] cmd_addr;
    logic                      addr_oor;
    logic                      out_of_rst;
    logic                      accept;
    logic                      wr_en;
    logic                      rd_acc;

    logic                      rd_inflight;
    logic [MEM_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_zero;
    logic [TDW-1:0]            rd_data;

    logic [CW-1:0]             fifo_count;
    logic                      fifo_empty;
    logic                      fifo_pop;

    logic [TDW-1:0]            mem [WORDS];

    assign cmd      = cmd_t'(s_axis_wr_tuser);
    assign cmd_addr = cmd.addr[MEM_ADDR_WIDTH-1:0];

`ifdef HBM_RSP_ADDR_CHECK_EN
    assign addr_oor = |cmd.addr[CMD_ADDR_MSB:MEM_ADDR_WIDTH];
`else
    assign addr_oor = 1'b0;
`endif

    // Credit covers queued responses plus the read currently in the RAM stage,
    // so an accepted read always finds a FIFO slot. Reads and writes share it.
    assign s_axis_wr_tready = out_of_rst && !ap_rst &&
                              ((fifo_count + CW'(rd_inflight)) < CW'(RSP_FIFO_DEPTH));

    assign accept = s_axis_wr_tvalid && s_axis_wr_tready;
    assign wr_en  = accept && (cmd.op == CMD_OP_WRITE) && !addr_oor;
    assign rd_acc = accept && (cmd.op == CMD_OP_READ);

    // tready stays low through reset and rises the cycle after release.
    always_ff @(posedge ap_clk) begin
        out_of_rst <= !ap_rst;
    end

    // Byte-enabled memory write; memory survives reset by design.
    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            for (int b = 0; b < KW; b++) begin
                if (s_axis_wr_tkeep[b]) mem[cmd_addr][b*8 +: 8] <= s_axis_wr_tdata[b*8 +: 8];
            end
        end
    end

    // Read stage register: address captured on acceptance, RAM read next cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_acc;
        end
        if (rd_acc) begin
            rd_addr <= cmd_addr;
            rd_zero <= addr_oor;
        end
    end

    // Reading a cycle after capture sees any write accepted in the capture cycle.
    assign rd_data  = rd_zero ? '0 : mem[rd_addr];
    assign fifo_pop = m_axis_rd_tvalid && m_axis_rd_tready;

    hbm_rsp_fifo #(
        .WIDTH (TDW),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .push  (rd_inflight),
        .din   (rd_data),
        .pop   (fifo_pop),
        .dout  (m_axis_rd_tdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_axis_rd_tvalid = !fifo_empty;
    assign m_axis_rd_tkeep  = '1;
    assign m_axis_rd_tlast  = 1'b1;

`ifdef HBM_RSP_ADDR_CHECK_EN
    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            o_addr_err <= 1'b0;
        end else if (accept && addr_oor) begin
            o_addr_err <= 1'b1;
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = ^{s_axis_wr_tlast, cmd.addr[CMD_ADDR_MSB:MEM_ADDR_WIDTH]};

endmodule

// File: tb/tb_hbm_cmd_responder.sv
// Scoreboard bench for hbm_cmd_responder: directed cases then a random mix.
module tb_hbm_cmd_responder;

    localparam int W   = 1024;
    localparam int K   = W / 8;
    localparam int MAW = 10;

    logic           ap_clk = 1'b0;
    logic           ap_rst = 1'b1;
    logic           s_tvalid = 1'b0;
    logic           s_tready;
    logic [W-1:0]   s_tdata = '0;
    logic [22:0]    s_tuser = '0;
    logic [K-1:0]   s_tkeep = '0;
    logic           s_tlast = 1'b1;
    logic           m_tvalid;
    logic           m_tready = 1'b0;
    logic [W-1:0]   m_tdata;
    logic [K-1:0]   m_tkeep;
    logic           m_tlast;
`ifdef HBM_RSP_ADDR_CHECK_EN
    logic           o_addr_err;
`endif

    always #5 ap_clk = ~ap_clk;

    hbm_cmd_responder dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .s_axis_wr_tvalid (s_tvalid),
        .s_axis_wr_tready (s_tready),
        .s_axis_wr_tdata  (s_tdata),
        .s_axis_wr_tuser  (s_tuser),
        .s_axis_wr_tkeep  (s_tkeep),
        .s_axis_wr_tlast  (s_tlast),
        .m_axis_rd_tvalid (m_tvalid),
        .m_axis_rd_tready (m_tready),
        .m_axis_rd_tdata  (m_tdata),
        .m_axis_rd_tkeep  (m_tkeep),
        .m_axis_rd_tlast  (m_tlast)
`ifdef HBM_RSP_ADDR_CHECK_EN
        ,
        .o_addr_err       (o_addr_err)
`endif
    );

    int           n_cmp = 0;
    int           n_err = 0;
    int           n_acc = 0;
    int           n_rsp = 0;
    int           rdy_mode = 1;   // 0 low, 1 high, 2 random
    logic [W-1:0] ref_mem [int];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] last_rsp = '0;
    logic         pv = 1'b0;
    logic         phs = 1'b0;
    logic [W-1:0] pd = '0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        int c;
        n_cmp++;
        if (got !== exp) begin
            c = 0;
            for (int i = W/64-1; i >= 0; i--) if (got[i*64 +: 64] !== exp[i*64 +: 64]) c = i;
            n_err++;
            $display("FAIL %s: 64b chunk %0d got %h expected %h", name, c, got[c*64 +: 64], exp[c*64 +: 64]);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [K-1:0] rand_keep();
        logic [K-1:0] r;
        for (int i = 0; i < K/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: memory as an array of words; each read's answer is
    // fixed at acceptance time, which is what in-order completion means.
    task automatic model_accept(input logic [22:0] u, input logic [W-1:0] d, input logic [K-1:0] k);
        int unsigned  a;
        int           idx;
        bit           oor;
        logic [W-1:0] w;
        a   = u[21:0];
        idx = a % (1 << MAW);
        oor = 1'b0;
`ifdef HBM_RSP_ADDR_CHECK_EN
        oor = (a >> MAW) != 0;
`endif
        if (u[22]) begin
            if (!oor) begin
                w = ref_mem.exists(idx) ? ref_mem[idx] : 'x;
                for (int b = 0; b < K; b++) if (k[b]) w[b*8 +: 8] = d[b*8 +: 8];
                ref_mem[idx] = w;
            end
        end else begin
            exp_q.push_back(oor ? '0 : ref_mem[idx]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic send(input bit wr, input int unsigned a, input logic [W-1:0] d, input logic [K-1:0] k);
        int cyc;
        cyc = 0;
        s_tvalid = 1'b1;
        s_tuser  = {wr, a[21:0]};
        s_tdata  = d;
        s_tkeep  = k;
        forever begin
            @(negedge ap_clk);
            if (s_tready) break;
            cyc++;
            if (cyc > 500) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: tready low for %0d cycles, required high", cyc);
                break;
            end
        end
        if (cyc <= 500) begin
            model_accept(s_tuser, d, k);
            n_acc++;
        end
        @(posedge ap_clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || m_tvalid) && cyc < 400) begin
            @(posedge ap_clk);
            #1;
            cyc++;
        end
        n_cmp++;
        if (cyc >= 400) begin
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    // Consumer ready driver.
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each response handshake and checks
    // that a presented response is held until taken.
    initial begin
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !phs) begin
                    chk("hold_valid", W'(m_tvalid), W'(1));
                    chk("hold_data", m_tdata, pd);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_rsp: response seen, required none outstanding");
                    end else begin
                        chk("rsp_data", m_tdata, exp_q.pop_front());
                    end
                    chk("rsp_tlast", W'(m_tlast), W'(1));
                    chk("rsp_tkeep", W'(m_tkeep), W'({K{1'b1}}));
                    last_rsp = m_tdata;
                    n_rsp++;
                end
                pv  = m_tvalid;
                phs = m_tvalid && m_tready;
                pd  = m_tdata;
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] aa;
        logic [W-1:0] c0;
        int           base;
        int unsigned  a;

        aa = {128{8'hAA}};
        c0 = {64{16'h1234}};

        // Reset state
        ap_rst = 1'b1;
        idle(3);
        chk("rst_tready", W'(s_tready), W'(0));
        chk("rst_tvalid", W'(m_tvalid), W'(0));
        chk("rst_tdata", m_tdata, '0);
`ifdef HBM_RSP_ADDR_CHECK_EN
        chk("rst_addr_err", W'(o_addr_err), W'(0));
`endif
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("tready_release_cycle", W'(s_tready), W'(0));
        idle(1);
        chk("tready_after_release", W'(s_tready), W'(1));

        // Initialise the addresses the rest of the bench uses
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) send(1'b1, i, rand_word(), '1);

        // Write then read same address back to back, latency 2
        send(1'b1, 5, aa, '1);
        send(1'b0, 5, '0, '0);
        @(negedge ap_clk);
        chk("t1_valid_n1", W'(m_tvalid), W'(0));
        @(negedge ap_clk);
        chk("t1_valid_n2", W'(m_tvalid), W'(1));
        chk("t1_data", m_tdata, aa);
        idle(1);
        drain();

        // Partial byte write
        send(1'b1, 3, '1, '1);
        d = rand_word();
        d[7:0] = 8'h5C;
        send(1'b1, 3, d, K'(1));
        send(1'b0, 3, '0, '0);
        drain();
        chk("t2_data", last_rsp, {{127{8'hFF}}, 8'h5C});

        // Credit exhaustion with consumer stalled
        rdy_mode = 0;
        idle(2);
        n_acc = 0;
        base  = n_rsp;
        fork
            begin
                for (int i = 0; i < 6; i++) send(1'b0, 4 + i, '0, '0);
            end
            begin
                idle(12);
                chk("t3_accepted", W'(n_acc), W'(4));
                chk("t3_tready_low", W'(s_tready), W'(0));
                chk("t3_no_rsp_yet", W'(n_rsp - base), W'(0));
                rdy_mode = 1;
            end
        join
        drain();
        chk("t3_total_acc", W'(n_acc), W'(6));
        chk("t3_total_rsp", W'(n_rsp - base), W'(6));

        // Reset with two queued responses and one read in flight
        rdy_mode = 0;
        idle(2);
        send(1'b0, 1, '0, '0);
        send(1'b0, 2, '0, '0);
        send(1'b0, 6, '0, '0);
        ap_rst = 1'b1;
        idle(1);
        chk("t4_rst_tvalid", W'(m_tvalid), W'(0));
        chk("t4_rst_tready", W'(s_tready), W'(0));
        exp_q.delete();
        base = n_rsp;
        idle(1);
        ap_rst = 1'b0;
        rdy_mode = 1;
        idle(10);
        chk("t4_no_stale", W'(n_rsp - base), W'(0));
        send(1'b0, 5, '0, '0);
        drain();
        chk("t4_mem_retained", last_rsp, aa);

        // Address beyond memory depth
        send(1'b1, 0, c0, '1);
        send(1'b0, 22'h400, '0, '0);
`ifdef HBM_RSP_ADDR_CHECK_EN
        @(negedge ap_clk);
        chk("t5_addr_err_set", W'(o_addr_err), W'(1));
        drain();
        chk("t5_oor_zero", last_rsp, '0);
`else
        drain();
        chk("t5_wrap", last_rsp, c0);
`endif

        // Random mix
        rdy_mode = 2;
        for (int n = 0; n < 10000; n++) begin
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 15) == 0) a = a + ($urandom_range(1, 4095) << MAW);
            send($urandom_range(0, 1) != 0, a, rand_word(), rand_keep());
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rdy_mode = 1;
        idle(2);
        drain();
`ifdef HBM_RSP_ADDR_CHECK_EN
        chk("addr_err_sticky", W'(o_addr_err), W'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
